minisrc_control_unit: RTL and testbench

- Hardwired control sequencer for the MiniSRC datapath.
- Runs the fetch steps T0–T2, then decodes the opcode in IR[31:27] and emits the one-cycle-per-step control strobes that the datapath consumes (bus-out selects, register enables, ALU op, memory Read/Write, select-and-encode Gra/Grb/Grc/Rin/Rout/BAout, port controls).
- Replaces the hand-written per-step stimulus used in datapath benches, and becomes the CPU top's controller.

---
 rtl/minisrc_ctrl_pkg.sv | 70 +++++++
 rtl/minisrc_op_decode.sv | 50 +++++
 rtl/minisrc_control_unit.sv | 156 +++++++++++++++
 tb/tb_minisrc_control_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_ctrl_pkg.sv
// Shared encodings for the MiniSRC hardwired controller: opcodes, states, ALU op bits, opcode classes.
// Latency: none (declarations and a pure helper function only).
// Backpressure: none; the controller never stalls, only the final-step length depends on the class.
package minisrc_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  // Bit positions inside the one-hot AluOp bus.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_SHR  = 4;
  localparam int ALU_SHRA = 5;
  localparam int ALU_SHL  = 6;
  localparam int ALU_ROR  = 7;
  localparam int ALU_ROL  = 8;
  localparam int ALU_MUL  = 9;
  localparam int ALU_DIV  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_LOAD, CL_LDI, CL_STORE, CL_ALU3, CL_ALUI, CL_MULDIV, CL_UNARY, CL_BRANCH,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } op_class_t;

  // Final execute step of each class; the step after it is T0 (or HALT).
  function automatic state_t last_step(input op_class_t cls);
    case (cls)
      CL_LOAD, CL_STORE:                 last_step = ST_T7;
      CL_MULDIV, CL_BRANCH:              last_step = ST_T6;
      CL_LDI, CL_ALU3, CL_ALUI:          last_step = ST_T5;
      CL_UNARY, CL_JAL:                  last_step = ST_T4;
      default:                           last_step = ST_T3;
    endcase
  endfunction

endpackage

// File: rtl/minisrc_op_decode.sv
// Opcode decoder: maps the 5-bit opcode to its execution class and one-hot ALU operation.
// Latency: purely combinational.
// Backpressure: none.
module minisrc_op_decode
  import minisrc_ctrl_pkg::*;
#(
  parameter int ALU_OPS = 13
) (
  input  logic [4:0]         opc,
  output op_class_t          op_class,
  output logic [ALU_OPS-1:0] alu_op
);

  // Address arithmetic of ld/ldi/st/br uses ADD, so those classes also report ADD.
  always_comb begin
    op_class = CL_NOP;
    alu_op   = '0;
    case (opc)
      OP_LD:   begin op_class = CL_LOAD;   alu_op[ALU_ADD]  = 1'b1; end
      OP_LDI:  begin op_class = CL_LDI;    alu_op[ALU_ADD]  = 1'b1; end
      OP_ST:   begin op_class = CL_STORE;  alu_op[ALU_ADD]  = 1'b1; end
      OP_ADD:  begin op_class = CL_ALU3;   alu_op[ALU_ADD]  = 1'b1; end
      OP_SUB:  begin op_class = CL_ALU3;   alu_op[ALU_SUB]  = 1'b1; end
      OP_AND:  begin op_class = CL_ALU3;   alu_op[ALU_AND]  = 1'b1; end
      OP_OR:   begin op_class = CL_ALU3;   alu_op[ALU_OR]   = 1'b1; end
      OP_ROR:  begin op_class = CL_ALU3;   alu_op[ALU_ROR]  = 1'b1; end
      OP_ROL:  begin op_class = CL_ALU3;   alu_op[ALU_ROL]  = 1'b1; end
      OP_SHR:  begin op_class = CL_ALU3;   alu_op[ALU_SHR]  = 1'b1; end
      OP_SHRA: begin op_class = CL_ALU3;   alu_op[ALU_SHRA] = 1'b1; end
      OP_SHL:  begin op_class = CL_ALU3;   alu_op[ALU_SHL]  = 1'b1; end
      OP_ADDI: begin op_class = CL_ALUI;   alu_op[ALU_ADD]  = 1'b1; end
      OP_ANDI: begin op_class = CL_ALUI;   alu_op[ALU_AND]  = 1'b1; end
      OP_ORI:  begin op_class = CL_ALUI;   alu_op[ALU_OR]   = 1'b1; end
      OP_MUL:  begin op_class = CL_MULDIV; alu_op[ALU_MUL]  = 1'b1; end
      OP_DIV:  begin op_class = CL_MULDIV; alu_op[ALU_DIV]  = 1'b1; end
      OP_NEG:  begin op_class = CL_UNARY;  alu_op[ALU_NEG]  = 1'b1; end
      OP_NOT:  begin op_class = CL_UNARY;  alu_op[ALU_NOT]  = 1'b1; end
      OP_BR:   begin op_class = CL_BRANCH; alu_op[ALU_ADD]  = 1'b1; end
      OP_JR:   op_class = CL_JR;
      OP_JAL:  op_class = CL_JAL;
      OP_IN:   op_class = CL_IN;
      OP_OUT:  op_class = CL_OUT;
      OP_MFHI: op_class = CL_MFHI;
      OP_MFLO: op_class = CL_MFLO;
      OP_HALT: op_class = CL_HALT;
      default: op_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/minisrc_control_unit.sv
// MiniSRC hardwired controller: fetch T0-T2, then opcode-driven execute steps T3-T7; optional MINISRC_CTRL_SINGLE_STEP_EN adds a Step gate.
// Latency: one state per clock; 4 to 8 cycles per instruction depending on opcode class.
// Backpressure: none free-running; with single-step the final step is held (outputs quiet) until Step=1.
module minisrc_control_unit
  import minisrc_ctrl_pkg::*;
#(
  parameter int IR_W    = 32,
  parameter int OPC_MSB = 31,
  parameter int ALU_OPS = 13
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic [IR_W-1:0]    IR,
  input  logic               CON_FF,
`ifdef MINISRC_CTRL_SINGLE_STEP_EN
  input  logic               Step,
`endif
  output logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
  output logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortIn,
  output logic IncPC, Read, Write,
  output logic Gra, Grb, Grc, Rin, Rout, BAout, LinkRin,
  output logic [ALU_OPS-1:0] AluOp,
  output logic               Run
);

  state_t             state, state_nxt;
  op_class_t          op_class;
  logic [ALU_OPS-1:0] dec_alu;
  logic               step_ok, hold_idle, ir_unused;

  // Only the opcode field steers the sequence; the rest of IR belongs to the datapath.
  assign ir_unused = ^IR;

  minisrc_op_decode #(.ALU_OPS(ALU_OPS)) u_dec (
    .opc      (IR[OPC_MSB -: 5]),
    .op_class (op_class),
    .alu_op   (dec_alu)
  );

`ifdef MINISRC_CTRL_SINGLE_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  // Final step waiting for Step: hold state and keep every strobe quiet.
  assign hold_idle = (state == last_step(op_class)) && !step_ok;

  // State register; Clear wins over everything, including mid-instruction.
  always_ff @(posedge Clock) begin
    if (!Clear) state <= ST_RST;
    else        state <= state_nxt;
  end

  // Next-state selection and per-step control strobes.
  always_comb begin
    state_nxt = state;
    {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortIn} = '0;
    {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, LinkRin} = '0;
    AluOp = '0;
    Run   = 1'b0;
    case (state)
      ST_RST:  state_nxt = ST_T0;
      ST_HALT: state_nxt = ST_HALT;
      default: begin
        if (state == last_step(op_class)) begin
          if (step_ok) state_nxt = (op_class == CL_HALT) ? ST_HALT : ST_T0;
        end else begin
          state_nxt = state_t'(state + 4'd1);
        end
        if (!hold_idle) begin
          Run = 1'b1;
          case (state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            default: begin
              case (op_class)
                CL_LOAD, CL_LDI, CL_STORE: begin
                  case (state)
                    ST_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    ST_T4: begin Cout = 1'b1; AluOp = dec_alu; Zin = 1'b1; end
                    ST_T5: begin
                      Zlowout = 1'b1;
                      if (op_class == CL_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                      else MARin = 1'b1;
                    end
                    ST_T6: begin
                      MDRin = 1'b1;
                      if (op_class == CL_LOAD) Read = 1'b1;
                      else begin Gra = 1'b1; Rout = 1'b1; end
                    end
                    ST_T7: begin
                      if (op_class == CL_LOAD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                      else Write = 1'b1;
                    end
                    default: ;
                  endcase
                end
                CL_ALU3, CL_ALUI: begin
                  case (state)
                    ST_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    ST_T4: begin
                      if (op_class == CL_ALU3) begin Grc = 1'b1; Rout = 1'b1; end
                      else Cout = 1'b1;
                      AluOp = dec_alu; Zin = 1'b1;
                    end
                    ST_T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                  endcase
                end
                CL_MULDIV: begin
                  case (state)
                    ST_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    ST_T4: begin Grb = 1'b1; Rout = 1'b1; AluOp = dec_alu; Zin = 1'b1; end
                    ST_T5: begin Zlowout = 1'b1; LOin = 1'b1; end
                    ST_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
                    default: ;
                  endcase
                end
                CL_UNARY: begin
                  case (state)
                    ST_T3: begin Grb = 1'b1; Rout = 1'b1; AluOp = dec_alu; Zin = 1'b1; end
                    ST_T4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                  endcase
                end
                CL_BRANCH: begin
                  case (state)
                    ST_T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    ST_T4: begin PCout = 1'b1; Yin = 1'b1; end
                    ST_T5: begin Cout = 1'b1; AluOp = dec_alu; Zin = 1'b1; end
                    ST_T6: begin Zlowout = 1'b1; PCin = CON_FF; end
                    default: ;
                  endcase
                end
                CL_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                CL_JAL: begin
                  if (state == ST_T3) begin PCout = 1'b1; LinkRin = 1'b1; Rin = 1'b1; end
                  else begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                end
                CL_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CL_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
                CL_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CL_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
              endcase
            end
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_minisrc_control_unit.sv
// Bench for the MiniSRC controller: per-cycle strobe tables checked through an expected-value queue.
// Latency: one queued record consumed per clock.
// Backpressure: none; every wait is a fixed number of cycles.
module tb_minisrc_control_unit;

  logic        Clock, Clear, CON_FF;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortIn;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, LinkRin;
  logic [12:0] AluOp;
  logic        Run;

  minisrc_control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortIn(OutPortIn),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .LinkRin(LinkRin),
    .AluOp(AluOp), .Run(Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Strobe vector order: PCout (bit 27) down to LinkRin (bit 0).
  localparam logic [27:0] PCOUT = 28'd1 << 27, ZLOWOUT = 28'd1 << 26, ZHIGHOUT = 28'd1 << 25;
  localparam logic [27:0] MDROUT = 28'd1 << 24, HIOUT = 28'd1 << 23, LOOUT = 28'd1 << 22;
  localparam logic [27:0] INPORTOUT = 28'd1 << 21, COUT = 28'd1 << 20, MARIN = 28'd1 << 19;
  localparam logic [27:0] ZIN = 28'd1 << 18, PCIN = 28'd1 << 17, MDRIN = 28'd1 << 16;
  localparam logic [27:0] IRIN = 28'd1 << 15, YIN = 28'd1 << 14, HIIN = 28'd1 << 13;
  localparam logic [27:0] LOIN = 28'd1 << 12, CONIN = 28'd1 << 11, OUTPORTIN = 28'd1 << 10;
  localparam logic [27:0] INCPC = 28'd1 << 9, READ = 28'd1 << 8, WRITE = 28'd1 << 7;
  localparam logic [27:0] GRA = 28'd1 << 6, GRB = 28'd1 << 5, GRC = 28'd1 << 4;
  localparam logic [27:0] RIN = 28'd1 << 3, ROUT = 28'd1 << 2, BAOUT = 28'd1 << 1, LINKRIN = 28'd1;
  localparam logic [27:0] F0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [27:0] F1 = ZLOWOUT | PCIN | READ | MDRIN;
  localparam logic [27:0] F2 = MDROUT | IRIN;

  localparam logic [12:0] A_ADD = 13'd1 << 0, A_SUB = 13'd1 << 1, A_OR = 13'd1 << 3;
  localparam logic [12:0] A_ROR = 13'd1 << 7, A_MUL = 13'd1 << 9, A_DIV = 13'd1 << 10;
  localparam logic [12:0] A_NEG = 13'd1 << 11, A_NOT = 13'd1 << 12;

  typedef struct {
    string             nm;
    logic [31:0]       ir;
    logic              con;
    int                n;
    logic [7:0][27:0]  ctl;
    logic [7:0][12:0]  alu;
  } vec_t;

  typedef struct {
    string       nm;
    logic [27:0] ctl;
    logic [12:0] alu;
    logic        run;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input string nm, input logic [31:0] ir, input logic con, input int n);
    vec_t v;
    v.nm = nm; v.ir = ir; v.con = con; v.n = n;
    v.ctl = '0; v.alu = '0;
    v.ctl[0] = F0; v.ctl[1] = F1; v.ctl[2] = F2;
    return v;
  endfunction

  task automatic push(input string nm, input logic [27:0] c, input logic [12:0] a, input logic r);
    exp_t e;
    e.nm = nm; e.ctl = c; e.alu = a; e.run = r;
    sbq.push_back(e);
  endtask

  // Compare the current cycle against the oldest queued record, then advance one clock.
  task automatic check_cycle();
    exp_t        e;
    logic [27:0] act;
    if (sbq.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: no expected record queued");
    end else begin
      e = sbq.pop_front();
      act = {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
             MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortIn,
             IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, LinkRin};
      n_checks++;
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL %s strobes: got %h want %h", e.nm, act, e.ctl);
      end
      n_checks++;
      if (AluOp !== e.alu) begin
        n_fail++;
        $display("FAIL %s AluOp: got %h want %h", e.nm, AluOp, e.alu);
      end
      n_checks++;
      if (Run !== e.run) begin
        n_fail++;
        $display("FAIL %s Run: got %b want %b", e.nm, Run, e.run);
      end
    end
    @(posedge Clock);
    #2;
  endtask

  initial begin
    vec_t v;
    // ---- instruction table: fetch prefilled by mk(), execute steps listed per opcode
    v = mk("ld", 32'h00800075, 1'b0, 8);
    v.ctl[3] = GRB | BAOUT | YIN; v.ctl[4] = COUT | ZIN; v.alu[4] = A_ADD;
    v.ctl[5] = ZLOWOUT | MARIN; v.ctl[6] = READ | MDRIN; v.ctl[7] = MDROUT | GRA | RIN;
    tbl.push_back(v);
    v = mk("addi", 32'h61A7FFFB, 1'b0, 6);
    v.ctl[3] = GRB | ROUT | YIN; v.ctl[4] = COUT | ZIN; v.alu[4] = A_ADD;
    v.ctl[5] = ZLOWOUT | GRA | RIN;
    tbl.push_back(v);
    v = mk("mul", 32'h78000000, 1'b0, 7);
    v.ctl[3] = GRA | ROUT | YIN; v.ctl[4] = GRB | ROUT | ZIN; v.alu[4] = A_MUL;
    v.ctl[5] = ZLOWOUT | LOIN; v.ctl[6] = ZHIGHOUT | HIIN;
    tbl.push_back(v);
    v = mk("br_c0", 32'h98000000, 1'b0, 7);
    v.ctl[3] = GRA | ROUT | CONIN; v.ctl[4] = PCOUT | YIN; v.ctl[5] = COUT | ZIN;
    v.alu[5] = A_ADD; v.ctl[6] = ZLOWOUT;
    tbl.push_back(v);
    v.nm = "br_c1"; v.con = 1'b1; v.ctl[6] = ZLOWOUT | PCIN;
    tbl.push_back(v);
    v = mk("st", 32'h10000000, 1'b0, 8);
    v.ctl[3] = GRB | BAOUT | YIN; v.ctl[4] = COUT | ZIN; v.alu[4] = A_ADD;
    v.ctl[5] = ZLOWOUT | MARIN; v.ctl[6] = GRA | ROUT | MDRIN; v.ctl[7] = WRITE;
    tbl.push_back(v);
    v = mk("ldi", 32'h08000000, 1'b0, 6);
    v.ctl[3] = GRB | BAOUT | YIN; v.ctl[4] = COUT | ZIN; v.alu[4] = A_ADD;
    v.ctl[5] = ZLOWOUT | GRA | RIN;
    tbl.push_back(v);
    v = mk("sub", 32'h20000000, 1'b0, 6);
    v.ctl[3] = GRB | ROUT | YIN; v.ctl[4] = GRC | ROUT | ZIN; v.alu[4] = A_SUB;
    v.ctl[5] = ZLOWOUT | GRA | RIN;
    tbl.push_back(v);
    v.nm = "ror"; v.ir = 32'h38000000; v.alu[4] = A_ROR;
    tbl.push_back(v);
    v = mk("ori", 32'h70000000, 1'b0, 6);
    v.ctl[3] = GRB | ROUT | YIN; v.ctl[4] = COUT | ZIN; v.alu[4] = A_OR;
    v.ctl[5] = ZLOWOUT | GRA | RIN;
    tbl.push_back(v);
    v = mk("div", 32'h80000000, 1'b0, 7);
    v.ctl[3] = GRA | ROUT | YIN; v.ctl[4] = GRB | ROUT | ZIN; v.alu[4] = A_DIV;
    v.ctl[5] = ZLOWOUT | LOIN; v.ctl[6] = ZHIGHOUT | HIIN;
    tbl.push_back(v);
    v = mk("neg", 32'h88000000, 1'b0, 5);
    v.ctl[3] = GRB | ROUT | ZIN; v.alu[3] = A_NEG; v.ctl[4] = ZLOWOUT | GRA | RIN;
    tbl.push_back(v);
    v.nm = "not"; v.ir = 32'h90000000; v.alu[3] = A_NOT;
    tbl.push_back(v);
    v = mk("jr", 32'hA0000000, 1'b0, 4);
    v.ctl[3] = GRA | ROUT | PCIN;
    tbl.push_back(v);
    v = mk("jal", 32'hA8000000, 1'b0, 5);
    v.ctl[3] = PCOUT | LINKRIN | RIN; v.ctl[4] = GRA | ROUT | PCIN;
    tbl.push_back(v);
    v = mk("in", 32'hB0000000, 1'b0, 4);
    v.ctl[3] = INPORTOUT | GRA | RIN;
    tbl.push_back(v);
    v = mk("out", 32'hB8000000, 1'b0, 4);
    v.ctl[3] = GRA | ROUT | OUTPORTIN;
    tbl.push_back(v);
    v = mk("mfhi", 32'hC0000000, 1'b0, 4);
    v.ctl[3] = HIOUT | GRA | RIN;
    tbl.push_back(v);
    v = mk("mflo", 32'hC8000000, 1'b0, 4);
    v.ctl[3] = LOOUT | GRA | RIN;
    tbl.push_back(v);
    tbl.push_back(mk("nop", 32'hD0000000, 1'b0, 4));
    tbl.push_back(mk("undef30", 32'hF0000000, 1'b0, 4));

    // ---- reset state
    Clear = 1'b0; IR = 32'h0; CON_FF = 1'b0;
    @(posedge Clock); @(posedge Clock); #2;
    push("reset", '0, '0, 1'b0);
    Clear = 1'b1;
    check_cycle();

    // ---- Clear held low for three cycles while a ld sits in T5
    IR = 32'h00800075; #1;
    push("rstld_T0", F0, '0, 1'b1);
    push("rstld_T1", F1, '0, 1'b1);
    push("rstld_T2", F2, '0, 1'b1);
    push("rstld_T3", GRB | BAOUT | YIN, '0, 1'b1);
    push("rstld_T4", COUT | ZIN, A_ADD, 1'b1);
    for (int s = 0; s < 5; s++) check_cycle();
    Clear = 1'b0;
    push("rstld_T5", ZLOWOUT | MARIN, '0, 1'b1);
    check_cycle();
    push("rstld_rst1", '0, '0, 1'b0);
    push("rstld_rst2", '0, '0, 1'b0);
    check_cycle();
    check_cycle();
    Clear = 1'b1;
    push("rstld_rst3", '0, '0, 1'b0);
    check_cycle();

    // ---- table-driven instruction sequences; each one's T0 also proves the previous returned
    for (int i = 0; i < tbl.size(); i++) begin
      IR = tbl[i].ir; CON_FF = tbl[i].con; #1;
      for (int s = 0; s < tbl[i].n; s++)
        push($sformatf("%s_T%0d", tbl[i].nm, s), tbl[i].ctl[s], tbl[i].alu[s], 1'b1);
      for (int s = 0; s < tbl[i].n; s++) check_cycle();
    end

    // ---- halt: quiet T3, then HALT for 20+ cycles, then Clear restarts at T0
    IR = 32'hD8000000; CON_FF = 1'b0; #1;
    push("halt_T0", F0, '0, 1'b1);
    push("halt_T1", F1, '0, 1'b1);
    push("halt_T2", F2, '0, 1'b1);
    push("halt_T3", '0, '0, 1'b1);
    for (int s = 0; s < 21; s++) push($sformatf("halt_idle%0d", s), '0, '0, 1'b0);
    for (int s = 0; s < 25; s++) check_cycle();
    Clear = 1'b0;
    push("halt_clr_rst", '0, '0, 1'b0);
    check_cycle();
    Clear = 1'b1;
    push("halt_clr_rst2", '0, '0, 1'b0);
    check_cycle();
    push("halt_restart_T0", F0, '0, 1'b1);
    check_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
